// File: rtl/sw_input_port_pkg.sv
// Shared constants and helpers for the switch input peripheral:
// register addresses, counter width and a 32-bit popcount.
package sw_in_pkg;

  localparam logic [1:0] SW_ADDR_LEVEL = 2'd0;
  localparam logic [1:0] SW_ADDR_RISE  = 2'd1;
  localparam logic [1:0] SW_ADDR_FALL  = 2'd2;
  localparam logic [1:0] SW_ADDR_STAT  = 2'd3;

  localparam int SW_CNT_W = 16;

  function automatic logic [5:0] popcount32(input logic [31:0] v);
    logic [5:0] n;
    n = 6'd0;
    for (int i = 0; i < 32; i++) begin
      n = n + {5'd0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/sw_debounce_bit.sv
// One switch bit: 2-flop synchronizer, tick-sampled history and debounced level.
// o_rise/o_fall flag the edge on which the debounced level is about to change.
module sw_debounce_bit #(
  parameter int STABLE_SAMPLES = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic i_tick,
  input  logic i_raw,
  output logic o_deb,
  output logic o_rise,
  output logic o_fall
);

  localparam int HIST_D = STABLE_SAMPLES - 1;

  logic [1:0]        r_sync;
  logic [HIST_D-1:0] r_hist;
  logic              r_deb;
  logic [HIST_D:0]   w_window;
  logic              w_accept;

  // The current synced sample plus history forms the full acceptance window.
  assign w_window = {r_hist, r_sync[1]};

  // Accept a new level only on a tick when the whole window agrees and differs.
  always_comb begin
    w_accept = 1'b0;
    if (i_tick) begin
      if (((&w_window) && !r_deb) || (!(|w_window) && r_deb)) begin
        w_accept = 1'b1;
      end else begin
        w_accept = 1'b0;
      end
    end else begin
      w_accept = 1'b0;
    end
  end

  // Synchronizer, history shift and debounced level state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync <= 2'b00;
      r_hist <= {HIST_D{1'b0}};
      r_deb  <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], i_raw};
      if (i_tick) begin
        r_hist <= w_window[HIST_D-1:0];
      end
      if (w_accept) begin
        r_deb <= ~r_deb;
      end
    end
  end

  assign o_deb  = r_deb;
  assign o_rise = w_accept & ~r_deb;
  assign o_fall = w_accept &  r_deb;

endmodule

// File: rtl/sw_input_port.sv
// Switch bank input peripheral: debounced level to the LSU, sticky edge
// registers with clear-on-read, saturating change counter and a read port.
module sw_input_port
  import sw_in_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int TICK_DIV       = 50000,
  parameter int STABLE_SAMPLES = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw_raw_i,
  input  logic             rd_en_i,
  input  logic [1:0]       rd_addr_i,
  output logic [31:0]      rd_data_o,
  output logic [WIDTH-1:0] io_sw_o,
  output logic             irq_o
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  logic [PW-1:0]       r_presc;
  logic                w_tick;
  logic [WIDTH-1:0]    w_deb;
  logic [WIDTH-1:0]    w_rise;
  logic [WIDTH-1:0]    w_fall;
  logic [WIDTH-1:0]    r_rise_q;
  logic [WIDTH-1:0]    r_fall_q;
  logic [WIDTH-1:0]    r_chg_mask;
  logic [SW_CNT_W-1:0] r_cnt;
  logic [31:0]         r_rd_data;

  logic [WIDTH-1:0]    w_rise_nxt;
  logic [WIDTH-1:0]    w_fall_nxt;
  logic [SW_CNT_W-1:0] w_inc;
  logic [SW_CNT_W:0]   w_sum;
  logic [SW_CNT_W-1:0] w_cnt_nxt;
  logic [31:0]         w_rd_word;
  logic                w_irq;

  assign w_tick = (r_presc == PRESC_MAX);

  // Debounce sample prescaler.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_presc <= {PW{1'b0}};
    end else if (w_tick) begin
      r_presc <= {PW{1'b0}};
    end else begin
      r_presc <= r_presc + {{(PW-1){1'b0}}, 1'b1};
    end
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    sw_debounce_bit #(
      .STABLE_SAMPLES(STABLE_SAMPLES)
    ) u_deb (
      .clk   (clk),
      .rst   (rst),
      .i_tick(w_tick),
      .i_raw (sw_raw_i[g]),
      .o_deb (w_deb[g]),
      .o_rise(w_rise[g]),
      .o_fall(w_fall[g])
    );
  end

  assign w_irq = |(r_rise_q | r_fall_q);

  // Sticky update, counter next value and read mux; new edges win over clears.
  always_comb begin
    w_rise_nxt = r_rise_q | w_rise;
    w_fall_nxt = r_fall_q | w_fall;
    w_inc      = SW_CNT_W'(popcount32(32'(r_chg_mask)));
    w_sum      = {1'b0, r_cnt} + {1'b0, w_inc};
    w_cnt_nxt  = w_sum[SW_CNT_W] ? {SW_CNT_W{1'b1}} : w_sum[SW_CNT_W-1:0];
    w_rd_word  = 32'd0;
    case (rd_addr_i)
      SW_ADDR_LEVEL: w_rd_word = 32'(w_deb);
      SW_ADDR_RISE:  w_rd_word = 32'(r_rise_q);
      SW_ADDR_FALL:  w_rd_word = 32'(r_fall_q);
      SW_ADDR_STAT:  w_rd_word = {r_cnt, 15'd0, w_irq};
      default:       w_rd_word = 32'd0;
    endcase
    if (rd_en_i) begin
      if (rd_addr_i == SW_ADDR_RISE) begin
        w_rise_nxt = w_rise;
      end else if (rd_addr_i == SW_ADDR_FALL) begin
        w_fall_nxt = w_fall;
      end else if (rd_addr_i == SW_ADDR_STAT) begin
        w_cnt_nxt = w_inc;
      end else begin
        w_cnt_nxt = w_cnt_nxt;
      end
    end else begin
      w_rd_word = r_rd_data;
    end
  end

  // Edge registers, change mask, counter and read data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rise_q   <= {WIDTH{1'b0}};
      r_fall_q   <= {WIDTH{1'b0}};
      r_chg_mask <= {WIDTH{1'b0}};
      r_cnt      <= {SW_CNT_W{1'b0}};
      r_rd_data  <= 32'd0;
    end else begin
      r_rise_q   <= w_rise_nxt;
      r_fall_q   <= w_fall_nxt;
      r_chg_mask <= w_rise | w_fall;
      r_cnt      <= w_cnt_nxt;
      r_rd_data  <= w_rd_word;
    end
  end

  assign rd_data_o = r_rd_data;
  assign io_sw_o   = w_deb;
  assign irq_o     = w_irq;

endmodule

// File: doc/sw_input_port.md
# sw_input_port

Memory-mapped input peripheral for the pipeline's switch bank. It synchronizes and debounces the raw board switches and drives the clean level onto the LSU `io_sw` input. It also captures rising and falling edges in sticky event registers that the CPU reads and clears through a small read port. The output peripherals (hex, LEDR, LEDG, LCD) carry data from the CPU to the board; this block carries board input back to the CPU.

## Interface
- `WIDTH`, 32, number of switch bits.
- `TICK_DIV`, 50000, clock cycles per debounce sample tick (≥2).
- `STABLE_SAMPLES`, 3, consecutive equal ticks required to accept a new level (≥2).

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-low.
- `sw_raw_i` in WIDTH: raw asynchronous switch pins.
- `rd_en_i` in 1: read strobe, one cycle per access.
- `rd_addr_i` in 2: register select.
- `rd_data_o` out 32: registered read data.
- `io_sw_o` out WIDTH: debounced switch level, connects to LSU `io_sw`.
- `irq_o` out 1: high while any sticky edge bit is set.

## Operation
- Each bit passes through a 2-flop synchronizer with a reset value of 0.
- Prescaler:
  - Counts 0..TICK_DIV-1, then wraps.
  - `tick` is high for one cycle when count == TICK_DIV-1.
- Per-bit debounce:
  - On `tick`, a history shift register of depth STABLE_SAMPLES-1 shifts in the synced bit.
  - On the same edge, if the synced bit and all history entries are equal and differ from `deb`, `deb` takes that value.
  - A glitch shorter than STABLE_SAMPLES ticks never changes `deb`.
- Edge capture:
  - When `deb` goes 0→1, the bit is set in `rise_q`.
  - When `deb` goes 1→0, the bit is set in `fall_q`.
  - Both registers are sticky.
- Change counter: a 16-bit counter adds the number of bits whose `deb` changes in a cycle (popcount) and saturates at 0xFFFF.
- Read map, selected by `rd_addr_i`:
  - 0: `deb` level.
  - 1: `rise_q`; the read clears `rise_q`.
  - 2: `fall_q`; the read clears `fall_q`.
  - 3: {change counter[15:0], 15'b0, `irq_o`}; the read clears the counter.
- Clear-on-read only clears bits that were returned. An edge detected on the same cycle as the clear stays set, because set wins. The counter follows the same rule: a clear in the same cycle as an increment leaves the counter equal to the increment.
- Reads when `rd_en_i` is low are ignored, and `rd_data_o` holds its value.
- `irq_o` = |(`rise_q` | `fall_q`), combinational from the registers.
- Reset values: all synchronizers, history, `deb`, `rise_q`, `fall_q`, the prescaler, the counter, and `rd_data_o` are 0. Therefore `io_sw_o` = 0 and `irq_o` = 0. If a switch is held at 1 through reset, a rising edge is logged after debounce. This is intended.
- Reset mid-debounce discards partial history.

## Timing
- Read latency: 1 cycle. `rd_data_o` is valid the cycle after `rd_en_i`. The clear takes effect on that same edge.
- Back-to-back reads are allowed every cycle.
- Raw change to `io_sw_o` change:
  - Minimum: 2 + (STABLE_SAMPLES-1)·TICK_DIV + 1 cycles.
  - Maximum: 2 + STABLE_SAMPLES·TICK_DIV cycles.
- `rise_q`/`fall_q` and `irq_o` update on the same edge as `deb`.
- The counter updates one edge after `deb`, from the registered change mask.

## Structure
- Package `sw_in_pkg` holds:
  - Address constants `SW_ADDR_LEVEL`=0, `SW_ADDR_RISE`=1, `SW_ADDR_FALL`=2, `SW_ADDR_STAT`=3.
  - Counter width `SW_CNT_W`=16.
- Sub-module `sw_debounce_bit`: synchronizer, history, and `deb` for one bit. It takes `tick` as an input and is instantiated WIDTH times by a generate loop.
- The top level holds the prescaler, edge and sticky logic, counter, and read mux.

## Test plan
Run with TICK_DIV=4 and STABLE_SAMPLES=3.
- Reset with `sw_raw_i`=0 → `io_sw_o`=0, `irq_o`=0; read addr 0 returns 0x00000000.
- `sw_raw_i`=0x00000005 held → `io_sw_o`=0x5 within 2+12 cycles. `irq_o`=1. Read addr 1 returns 0x5, a second read returns 0x0, and `irq_o`=0.
- Bit 3 pulsed high for 5 cycles (< 3 ticks) → `io_sw_o` is unchanged, `rise_q`=0, and addr 3 returns counter 0.
- Set then release bit 0 (each level held 20 cycles) → addr 1 returns 0x1, addr 2 returns 0x1, and addr 3 returns 0x00020001 before the edge reads and 0x00020000 after them.
- Read addr 1 on the exact cycle a new rising edge on bit 7 registers → returned data excludes bit 7, `rise_q`[7]=1 afterwards, and `irq_o` stays 1.
- Assert `rst` low mid-debounce (after 2 ticks of a new level) → all outputs are 0 immediately. After release, the level needs a full 3 ticks again.
